mem_responder: RTL
==================

# mem_responder

Memory-side responder for the single-request-per-cycle memory interface that the compute engines drive (`mem_req`/`mem_write`/`mem_addr`/`mem_wdata` out, `mem_rdata_vld`/`mem_rdata` back).
- Owns a word-addressed storage array.
- Accepts one request every cycle with no backpressure.
- Returns read data in order after a fixed, parameterised latency.
- Provides a lower-priority host port for preload and readback, plus request counters and a sticky range-error flag for bring-up.

## Interface
Parameters:
- MEM_AW, 16, address width.
- MEM_DW, 32, data width.
- DEPTH_LOG2, 10, log2 of array depth in words; must be ≤ MEM_AW.
- RD_LAT, 2, read latency in cycles; legal range 1..8.
- CNT_W, 16, width of the request counters.

Ports:
- clk  in  1  clock; rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- mem_req  in  1  request valid; every cycle it is high is one request.
- mem_write  in  1  1 = write, 0 = read; qualified by mem_req.
- mem_addr  in  MEM_AW  word address.
- mem_wdata  in  MEM_DW  write data.
- mem_rdata_vld  out  1  read-return strobe, one cycle per read.
- mem_rdata  out  MEM_DW  read data; valid only with mem_rdata_vld.
- host_req  in  1  host access request.
- host_we  in  1  host write enable.
- host_addr  in  MEM_AW  host address.
- host_wdata  in  MEM_DW  host write data.
- host_gnt  out  1  combinational: host_req & ~mem_req.
- host_rvld  out  1  host read-return strobe.
- host_rdata  out  MEM_DW  host read data.
- rd_cnt  out  CNT_W  accepted mem-port reads; wraps.
- wr_cnt  out  CNT_W  accepted mem-port writes; wraps.
- err  out  1  sticky out-of-range flag.
- err_clr  in  1  clears err.

## Operation
Acceptance and arbitration:
- Mem port always wins. A mem request is accepted in every cycle mem_req=1.
- A host access is accepted only in a cycle with host_gnt=1. The host holds host_req and its fields until it sees the grant.

Writes:
- An accepted write updates the array at the accepting clock edge.
- Back-to-back writes to the same address: the last one wins. Repeated identical writes are legal and harmless.

Reads:
- An accepted read samples the array at the accepting edge.
- The sampled value reflects every write accepted in earlier cycles. A write in cycle t is therefore visible to a read in cycle t+1.
- The read enters an RD_LAT-deep return pipeline. Each stage carries valid, a tag (mem or host) and data.
- Pipeline exit: a mem-tagged entry drives mem_rdata_vld/mem_rdata; a host-tagged entry drives host_rvld/host_rdata.
- Returns are strictly in acceptance order. At most one return occurs per cycle.

Range checking:
- An address with any bit at or above DEPTH_LOG2 set is out of range.
- Out-of-range write: dropped.
- Out-of-range read: still returns, with data 0 and normal latency.
- Either port sets err. err stays set until err_clr=1. If err_clr and a new error occur in the same cycle, set wins.

Counters:
- rd_cnt and wr_cnt increment on accepted mem-port reads and writes, including out-of-range ones.
- Host accesses are not counted. Counters wrap modulo 2^CNT_W.

## Timing
- Reset values: mem_rdata_vld=0, mem_rdata=0, host_rvld=0, host_rdata=0, rd_cnt=0, wr_cnt=0, err=0. host_gnt follows its inputs.
- Array contents are not reset.
- Read latency: a read presented in cycle t gives a valid return in cycle t+RD_LAT.
- Data outputs hold their last returned value when not valid.
- Throughput: one read per cycle. The pipeline needs no stall and no storage beyond RD_LAT stages.
- Reset asserted mid-operation: all pipeline stages are cleared and in-flight reads are lost. No valid strobe appears until a new read is accepted after reset release. Writes accepted before reset persist.
- Write to address A in cycle t, read of A in cycle t+1: the read returns the new data in cycle t+1+RD_LAT.
- host_req held during continuous mem traffic: host_gnt stays 0, with no timeout. The host access completes in the first cycle with mem_req=0.

## Test plan
- Preload via host: write addr 0..15 with value 100+addr, each write waiting for host_gnt. Then mem reads of addr 3 and addr 7 in consecutive cycles (RD_LAT=2) -> mem_rdata_vld in cycles t+2 and t+3, with data 103 then 107; rd_cnt=2.
- Write/read hazard: mem write addr 5 = 0xDEADBEEF in cycle t, mem read addr 5 in cycle t+1 -> mem_rdata=0xDEADBEEF in cycle t+3; wr_cnt=1.
- Streaming: mem reads every cycle for 64 cycles with alternating A/B addresses (matmul pattern) -> 64 consecutive vld cycles, in order, with no gaps.
- Arbitration: host read of addr 2 held while mem_req=1 for 10 cycles -> host_gnt=0 throughout. Grant comes in the first idle cycle, and host_rvld arrives RD_LAT later with the correct data. mem_rdata_vld never pulses for the host read.
- Range error (DEPTH_LOG2=10): mem write to 0x0400, then read of 0x0400 -> write dropped, read returns 0, err=1. The error is still present after 5 idle cycles; err_clr -> err=0 next cycle.
- Reset mid-flight: issue 2 reads, then assert rst_n low 1 cycle after the second -> no mem_rdata_vld pulse after reset. Counters are 0, and preloaded data still reads back correctly.

Source files
------------

// File: rtl/mem_responder.sv
`timescale 1ns/1ps
// Memory-side responder: word-addressed array with a fixed-latency in-order read
// return pipeline, a lower-priority host port, request counters and a sticky range error.
module mem_responder #(
  parameter int MEM_AW     = 16,
  parameter int MEM_DW     = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int RD_LAT     = 2,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_req,
  input  logic              mem_write,
  input  logic [MEM_AW-1:0] mem_addr,
  input  logic [MEM_DW-1:0] mem_wdata,
  output logic              mem_rdata_vld,
  output logic [MEM_DW-1:0] mem_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [MEM_AW-1:0] host_addr,
  input  logic [MEM_DW-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvld,
  output logic [MEM_DW-1:0] host_rdata,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic              err,
  input  logic              err_clr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic                  acc_vld;
  logic                  acc_we;
  logic                  acc_host;
  logic                  acc_oor;
  logic [MEM_AW-1:0]     acc_addr;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic [MEM_DW-1:0]     acc_wdata;
  logic [MEM_DW-1:0]     acc_rdata;

  logic [MEM_DW-1:0] mem_array_q [DEPTH];

  logic [RD_LAT-1:0]             pipe_vld_q,  pipe_vld_d;
  logic [RD_LAT-1:0]             pipe_host_q, pipe_host_d;
  logic [RD_LAT-1:0][MEM_DW-1:0] pipe_data_q, pipe_data_d;

  logic              exit_mem;
  logic              exit_host;
  logic [MEM_DW-1:0] mem_rdata_hold_q, mem_rdata_hold_d;
  logic [MEM_DW-1:0] host_rdata_hold_q, host_rdata_hold_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic              err_q, err_d;

  // The mem port always wins; the host only gets the array in cycles the mem port is idle.
  // NOTE: always_comb uses blocking '=' and gives every output a value on every path, so no latch is inferred.
  always_comb begin
    host_gnt  = host_req & ~mem_req;
    acc_vld   = mem_req | host_gnt;
    acc_host  = ~mem_req;
    acc_we    = mem_req ? mem_write : host_we;
    acc_addr  = mem_req ? mem_addr  : host_addr;
    acc_wdata = mem_req ? mem_wdata : host_wdata;
    acc_oor   = |(acc_addr >> DEPTH_LOG2);
    acc_idx   = acc_addr[DEPTH_LOG2-1:0];
    acc_rdata = acc_oor ? '0 : mem_array_q[acc_idx];
  end

  // NOTE: the storage array has no reset so it maps onto RAM; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (acc_vld && acc_we && !acc_oor) begin
      mem_array_q[acc_idx] <= acc_wdata;
    end
  end

  // Return pipeline: stage 0 captures the sampled word, the last stage is the exit.
  always_comb begin
    pipe_vld_d     = '0;
    pipe_host_d    = '0;
    pipe_data_d    = '0;
    pipe_vld_d[0]  = acc_vld & ~acc_we;
    pipe_host_d[0] = acc_host;
    pipe_data_d[0] = acc_rdata;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_host_d[i] = pipe_host_q[i-1];
      pipe_data_d[i] = pipe_data_q[i-1];
    end
  end

  // Data outputs show the exiting word when valid and otherwise hold the last return.
  always_comb begin
    exit_mem          = pipe_vld_q[RD_LAT-1] & ~pipe_host_q[RD_LAT-1];
    exit_host         = pipe_vld_q[RD_LAT-1] &  pipe_host_q[RD_LAT-1];
    mem_rdata_hold_d  = exit_mem  ? pipe_data_q[RD_LAT-1] : mem_rdata_hold_q;
    host_rdata_hold_d = exit_host ? pipe_data_q[RD_LAT-1] : host_rdata_hold_q;
  end

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (mem_req && !mem_write) rd_cnt_d = rd_cnt_q + 1'b1;
    if (mem_req &&  mem_write) wr_cnt_d = wr_cnt_q + 1'b1;
    // A new error in the same cycle as err_clr keeps the flag set.
    if (acc_vld && acc_oor) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_q        <= '0;
      pipe_host_q       <= '0;
      pipe_data_q       <= '0;
      mem_rdata_hold_q  <= '0;
      host_rdata_hold_q <= '0;
      rd_cnt_q          <= '0;
      wr_cnt_q          <= '0;
      err_q             <= 1'b0;
    end else begin
      pipe_vld_q        <= pipe_vld_d;
      pipe_host_q       <= pipe_host_d;
      pipe_data_q       <= pipe_data_d;
      mem_rdata_hold_q  <= mem_rdata_hold_d;
      host_rdata_hold_q <= host_rdata_hold_d;
      rd_cnt_q          <= rd_cnt_d;
      wr_cnt_q          <= wr_cnt_d;
      err_q             <= err_d;
    end
  end

  assign mem_rdata_vld = exit_mem;
  assign mem_rdata     = mem_rdata_hold_d;
  assign host_rvld     = exit_host;
  assign host_rdata    = host_rdata_hold_d;
  assign rd_cnt        = rd_cnt_q;
  assign wr_cnt        = wr_cnt_q;
  assign err           = err_q;

endmodule
